// File: rtl/hwpe_color_conv_ctrl_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// hwpe_color_conv_ctrl_if : job/command/stream-status bundle of the controller
// Revision 1.0
// ----------------------------------------------------------------------------
interface hwpe_color_conv_ctrl_if #(
  parameter int STREAM_WIDTH = 96,
  parameter int ADDR_WIDTH   = 32,
  parameter int NPIX_WIDTH   = 16
) ();
  logic                      start_i;
  logic [NPIX_WIDTH-1:0]     nb_pixels_i;
  logic [ADDR_WIDTH-1:0]     src_addr_i;
  logic [ADDR_WIDTH-1:0]     dst_addr_i;
  logic                      src_req_valid_o;
  logic                      src_req_ready_i;
  logic                      dst_req_valid_o;
  logic                      dst_req_ready_i;
  logic [ADDR_WIDTH-1:0]     src_req_addr_o;
  logic [ADDR_WIDTH-1:0]     dst_req_addr_o;
  logic [NPIX_WIDTH-1:0]     req_len_o;
  logic                      out_fire_i;
  logic                      dst_done_i;
  logic [STREAM_WIDTH/8-1:0] out_strb_o;
  logic                      busy_o;
  logic                      done_evt_o;

  modport master (
    input  start_i, nb_pixels_i, src_addr_i, dst_addr_i,
    input  src_req_ready_i, dst_req_ready_i, out_fire_i, dst_done_i,
    output src_req_valid_o, dst_req_valid_o, src_req_addr_o, dst_req_addr_o,
    output req_len_o, out_strb_o, busy_o, done_evt_o
  );

  modport slave (
    output start_i, nb_pixels_i, src_addr_i, dst_addr_i,
    output src_req_ready_i, dst_req_ready_i, out_fire_i, dst_done_i,
    input  src_req_valid_o, dst_req_valid_o, src_req_addr_o, dst_req_addr_o,
    input  req_len_o, out_strb_o, busy_o, done_evt_o
  );
endinterface
`default_nettype wire

// File: rtl/hwpe_color_conv_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// hwpe_color_conv_ctrl : job controller for the RGB->YCbCr HWPE datapath
// Revision 1.0
// ----------------------------------------------------------------------------
module hwpe_color_conv_ctrl #(
  parameter int STREAM_WIDTH = 96,
  parameter int ADDR_WIDTH   = 32,
  parameter int NPIX_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  hwpe_color_conv_ctrl_if.master ctrl
);
  localparam int PPB        = STREAM_WIDTH / 24;
  localparam int STRB_WIDTH = STREAM_WIDTH / 8;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CMD   = 3'd1;
  localparam logic [2:0] RUN   = 3'd2;
  localparam logic [2:0] DRAIN = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  localparam logic [NPIX_WIDTH:0]   PPB_EXT = (NPIX_WIDTH+1)'(PPB);
  localparam logic [NPIX_WIDTH:0]   PPB_M1  = (NPIX_WIDTH+1)'(PPB - 1);
  localparam logic [NPIX_WIDTH-1:0] PPB_N   = NPIX_WIDTH'(PPB);
  localparam logic [NPIX_WIDTH-1:0] ONE     = NPIX_WIDTH'(1);

  logic [2:0]            state;
  logic [NPIX_WIDTH-1:0] beat_cnt;
  logic [NPIX_WIDTH-1:0] nb_beats;
  logic [NPIX_WIDTH-1:0] rem;
  logic [ADDR_WIDTH-1:0] src_addr;
  logic [ADDR_WIDTH-1:0] dst_addr;
  logic                  src_pend;
  logic                  dst_pend;

  // One extra bit so the ceiling add cannot wrap at the maximum pixel count.
  logic [NPIX_WIDTH:0]   nb_ceil;
  logic [NPIX_WIDTH-1:0] nb_rem;
  logic                  unused_nb_msb;
  logic                  src_hs;
  logic                  dst_hs;
  logic                  last_beat;
  logic                  partial;
  logic [NPIX_WIDTH+1:0] shamt;

  assign nb_ceil       = ({1'b0, ctrl.nb_pixels_i} + PPB_M1) / PPB_EXT;
  assign nb_rem        = ctrl.nb_pixels_i % PPB_N;
  assign unused_nb_msb = nb_ceil[NPIX_WIDTH];

  assign src_hs    = src_pend & ctrl.src_req_ready_i;
  assign dst_hs    = dst_pend & ctrl.dst_req_ready_i;
  assign last_beat = (beat_cnt == nb_beats - ONE);

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      state    <= IDLE;
      beat_cnt <= '0;
      nb_beats <= '0;
      rem      <= '0;
      src_addr <= '0;
      dst_addr <= '0;
      src_pend <= 1'b0;
      dst_pend <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ctrl.start_i) begin
            src_addr <= ctrl.src_addr_i;
            dst_addr <= ctrl.dst_addr_i;
            nb_beats <= nb_ceil[NPIX_WIDTH-1:0];
            rem      <= nb_rem;
            if (ctrl.nb_pixels_i != '0) begin
              src_pend <= 1'b1;
              dst_pend <= 1'b1;
              state    <= CMD;
            end else begin
              state    <= DONE;
            end
          end
        end
        CMD: begin
          // Each command side retires on its own handshake.
          if (src_hs) src_pend <= 1'b0;
          if (dst_hs) dst_pend <= 1'b0;
          if ((!src_pend || src_hs) && (!dst_pend || dst_hs)) state <= RUN;
        end
        RUN: begin
          if (ctrl.out_fire_i) begin
            if (last_beat) begin
              beat_cnt <= '0;
              state    <= ctrl.dst_done_i ? DONE : DRAIN;
            end else begin
              beat_cnt <= beat_cnt + ONE;
            end
          end
        end
        DRAIN: begin
          if (ctrl.dst_done_i) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Three strobe bytes per pixel on the partial last beat.
  assign shamt   = {2'b00, rem} + {1'b0, rem, 1'b0};
  assign partial = (state == RUN) && last_beat && (rem != '0);

  assign ctrl.out_strb_o      = partial ? ~({STRB_WIDTH{1'b1}} << shamt) : {STRB_WIDTH{1'b1}};
  assign ctrl.src_req_valid_o = src_pend;
  assign ctrl.dst_req_valid_o = dst_pend;
  assign ctrl.src_req_addr_o  = src_addr;
  assign ctrl.dst_req_addr_o  = dst_addr;
  assign ctrl.req_len_o       = nb_beats;
  assign ctrl.busy_o          = (state != IDLE);
  assign ctrl.done_evt_o      = (state == DONE);
endmodule
`default_nettype wire

// File: tb/tb_hwpe_color_conv_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_hwpe_color_conv_ctrl : scoreboard bench for the colour-conversion job controller
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_hwpe_color_conv_ctrl;
  localparam int SW = 96;
  localparam int AW = 32;
  localparam int NW = 16;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [NW-1:0] len;
  } cmd_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  always #5 clk = ~clk;

  hwpe_color_conv_ctrl_if #(.STREAM_WIDTH(SW), .ADDR_WIDTH(AW), .NPIX_WIDTH(NW)) bus ();

  hwpe_color_conv_ctrl #(.STREAM_WIDTH(SW), .ADDR_WIDTH(AW), .NPIX_WIDTH(NW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .ctrl  (bus.master)
  );

  int checks   = 0;
  int failures = 0;
  cmd_t        src_q[$];
  cmd_t        dst_q[$];
  logic [11:0] strb_q[$];
  int          evt_q[$];
  bit          mon_en       = 1'b0;
  bit          fire_tracked = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    failures++;
    $display("FAIL %s: event seen with no expectation queued", name);
  endtask

  // Monitor: pops scoreboard entries whenever the DUT presents an event.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (bus.src_req_valid_o && bus.src_req_ready_i) begin
        if (src_q.size() == 0) unexpected("src_cmd");
        else begin
          cmd_t e;
          e = src_q.pop_front();
          check("src_addr", bus.src_req_addr_o, e.addr);
          check("src_len", bus.req_len_o, e.len);
        end
      end
      if (bus.dst_req_valid_o && bus.dst_req_ready_i) begin
        if (dst_q.size() == 0) unexpected("dst_cmd");
        else begin
          cmd_t e;
          e = dst_q.pop_front();
          check("dst_addr", bus.dst_req_addr_o, e.addr);
          check("dst_len", bus.req_len_o, e.len);
        end
      end
      if (bus.out_fire_i && fire_tracked) begin
        if (strb_q.size() == 0) unexpected("out_fire");
        else check("out_strb", bus.out_strb_o, strb_q.pop_front());
      end
      if (bus.done_evt_o) begin
        if (evt_q.size() == 0) unexpected("stale_evt");
        else begin
          void'(evt_q.pop_front());
          check("evt_busy", bus.busy_o, 1);
        end
      end
    end
  end

  task automatic do_start(input logic [NW-1:0] n, input logic [AW-1:0] s, input logic [AW-1:0] d,
                          input logic [NW-1:0] len, input bit expect_evt);
    if (n != 0) begin
      src_q.push_back('{addr: s, len: len});
      dst_q.push_back('{addr: d, len: len});
    end
    if (expect_evt) evt_q.push_back(1);
    @(posedge clk); #1;
    bus.start_i = 1'b1; bus.nb_pixels_i = n; bus.src_addr_i = s; bus.dst_addr_i = d;
    @(posedge clk); #1;
    bus.start_i     = 1'b0;
    bus.nb_pixels_i = NW'($urandom);
    bus.src_addr_i  = $urandom;
    bus.dst_addr_i  = $urandom;
  endtask

  task automatic wait_run();
    bit ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = bus.busy_o && !bus.src_req_valid_o && !bus.dst_req_valid_o;
    end
    check("run_reached", ok, 1);
  endtask

  task automatic fire(input int n, input bit done_on_last);
    fire_tracked = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      bus.out_fire_i = 1'b1;
      bus.dst_done_i = done_on_last && (i == n - 1);
    end
    @(posedge clk); #1;
    bus.out_fire_i = 1'b0;
    bus.dst_done_i = 1'b0;
    fire_tracked   = 1'b0;
  endtask

  task automatic drain_done();
    @(negedge clk);
    check("drain_no_evt", bus.done_evt_o, 0);
    check("drain_busy", bus.busy_o, 1);
    @(posedge clk); #1; bus.dst_done_i = 1'b1;
    @(posedge clk); #1; bus.dst_done_i = 1'b0;
    @(negedge clk);
    check("evt_after_drain", bus.done_evt_o, 1);
    @(negedge clk);
    check("evt_one_cycle", bus.done_evt_o, 0);
    check("idle_after_done", bus.busy_o, 0);
  endtask

  task automatic direct_done();
    @(negedge clk);
    check("evt_direct", bus.done_evt_o, 1);
    @(negedge clk);
    check("evt_direct_one_cycle", bus.done_evt_o, 0);
  endtask

  initial begin
    bus.start_i = 1'b0; bus.nb_pixels_i = '0; bus.src_addr_i = '0; bus.dst_addr_i = '0;
    bus.src_req_ready_i = 1'b1; bus.dst_req_ready_i = 1'b1;
    bus.out_fire_i = 1'b0; bus.dst_done_i = 1'b0;

    // T1 reset with start held high
    rst_n = 1'b0; bus.start_i = 1'b1; bus.nb_pixels_i = 16'd8;
    repeat (2) @(negedge clk);
    check("rst_busy", bus.busy_o, 0);
    check("rst_src_valid", bus.src_req_valid_o, 0);
    check("rst_dst_valid", bus.dst_req_valid_o, 0);
    check("rst_evt", bus.done_evt_o, 0);
    check("rst_strb", bus.out_strb_o, 12'hFFF);
    check("rst_len", bus.req_len_o, 0);
    @(posedge clk); #1;
    bus.start_i = 1'b0; rst_n = 1'b1; mon_en = 1'b1;

    // T2 full beats, release via DRAIN
    do_start(16'd8, 32'h1000_0000, 32'h2000_0000, 16'd2, 1'b1);
    wait_run();
    strb_q.push_back(12'hFFF); strb_q.push_back(12'hFFF);
    fire(2, 1'b0);
    drain_done();

    // Fires while idle must not advance the beat counter
    @(posedge clk); #1; bus.out_fire_i = 1'b1;
    repeat (2) @(posedge clk);
    #1; bus.out_fire_i = 1'b0;

    // T3 partial last beat: 9 pixels (direct done), then 6 pixels (drain)
    do_start(16'd9, 32'h1000_0100, 32'h2000_0100, 16'd3, 1'b1);
    wait_run();
    strb_q.push_back(12'hFFF); strb_q.push_back(12'hFFF); strb_q.push_back(12'h007);
    fire(3, 1'b1);
    direct_done();
    do_start(16'd6, 32'hABCD_0000, 32'h5555_AAA0, 16'd2, 1'b1);
    wait_run();
    strb_q.push_back(12'hFFF); strb_q.push_back(12'h03F);
    fire(2, 1'b0);
    drain_done();

    // T4 command backpressure: src ready in window 3, dst ready in window 5
    bus.src_req_ready_i = 1'b0; bus.dst_req_ready_i = 1'b0;
    do_start(16'd4, 32'h3000_0040, 32'h4000_0080, 16'd1, 1'b1);
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      check("bp_src_valid", bus.src_req_valid_o, (c <= 3) ? 1 : 0);
      check("bp_dst_valid", bus.dst_req_valid_o, (c <= 5) ? 1 : 0);
      check("bp_busy", bus.busy_o, 1);
      if (c < 6) begin
        @(posedge clk); #1;
        bus.src_req_ready_i = (c >= 2);
        bus.dst_req_ready_i = (c >= 4);
      end
    end
    strb_q.push_back(12'hFFF);
    fire(1, 1'b1);
    direct_done();

    // T5 zero-pixel job
    do_start(16'd0, 32'h0BAD_0000, 32'h0BAD_1000, 16'd0, 1'b1);
    @(negedge clk);
    check("zero_busy", bus.busy_o, 1);
    check("zero_evt", bus.done_evt_o, 1);
    @(negedge clk);
    check("zero_busy_after", bus.busy_o, 0);
    check("zero_evt_after", bus.done_evt_o, 0);

    // T6 clear mid-job, then a fresh 4-pixel job
    do_start(16'd12, 32'h6000_0000, 32'h7000_0000, 16'd3, 1'b0);
    wait_run();
    strb_q.push_back(12'hFFF);
    fire(1, 1'b0);
    clear = 1'b1;
    @(posedge clk); #1; clear = 1'b0;
    @(negedge clk);
    check("clear_busy", bus.busy_o, 0);
    check("clear_evt", bus.done_evt_o, 0);
    check("clear_strb", bus.out_strb_o, 12'hFFF);
    do_start(16'd4, 32'h6100_0000, 32'h7100_0000, 16'd1, 1'b1);
    wait_run();
    strb_q.push_back(12'hFFF);
    fire(1, 1'b0);
    drain_done();

    repeat (5) @(negedge clk);
    check("evt_q_empty", evt_q.size(), 0);
    check("strb_q_empty", strb_q.size(), 0);
    check("src_q_empty", src_q.size(), 0);
    check("dst_q_empty", dst_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
`default_nettype wire
